// File: rtl/ball_split_ctrl_pkg.sv
// ball_pkg: types and constants shared by the ball split controller, its
// bus interface and its testbench.
//   ball_size_t   : 2-bit size level (2=big, 1=medium, 0=small)
//   ball_state_e  : split sequencer states
//   DEF_NUM_SLOTS : default number of ball instances in the pool
package ball_pkg;

    typedef logic [1:0] ball_size_t;

    localparam ball_size_t SIZE_BIG   = 2'd2;
    localparam ball_size_t SIZE_MED   = 2'd1;
    localparam ball_size_t SIZE_SMALL = 2'd0;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        SPAWN_A,
        SPAWN_B
    } ball_state_e;

    localparam int unsigned DEF_NUM_SLOTS = 8;

endpackage

// File: rtl/ball_split_ctrl_if.sv
// ball_split_ctrl_if: signals between the ball split controller and its
// neighbours (frame timing, collision block, ball movement/bitmap slots).
//   master : drives frame/level pulses and the hit vector, observes the pool
//   slave  : the controller; consumes hits, drives visibility/size/spawn load
interface ball_split_ctrl_if
    import ball_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = DEF_NUM_SLOTS
);
    localparam int unsigned IDX_W = $clog2(NUM_SLOTS);

    logic                           startOfFrame;
    logic                           startLevel;
    logic       [NUM_SLOTS-1:0]     hit;
    logic       [10:0]              hitX;
    logic       [10:0]              hitY;
    logic       [NUM_SLOTS-1:0]     slotVisible;
    ball_size_t [NUM_SLOTS-1:0]     slotSize;
    logic                           spawnValid;
    logic       [IDX_W-1:0]         spawnSlot;
    logic       [10:0]              spawnX;
    logic       [10:0]              spawnY;
    logic                           spawnDirRight;
    logic                           popActive;
    logic                           allCleared;
    logic                           busy;

    modport master (
        output startOfFrame, startLevel, hit, hitX, hitY,
        input  slotVisible, slotSize, spawnValid, spawnSlot, spawnX, spawnY,
        input  spawnDirRight, popActive, allCleared, busy
    );

    modport slave (
        input  startOfFrame, startLevel, hit, hitX, hitY,
        output slotVisible, slotSize, spawnValid, spawnSlot, spawnX, spawnY,
        output spawnDirRight, popActive, allCleared, busy
    );

endinterface

// File: rtl/ball_split_ctrl_lowest_index_finder.sv
// lowest_index_finder: combinational priority encoder.
//   vec   : input vector
//   index : position of the lowest set bit (0 when none set)
//   found : high when any bit of vec is set
module lowest_index_finder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] index,
    output logic             found
);

    // Scan downwards so the lowest set bit is the last one to win.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ball_split_ctrl.sv
// ball_split_ctrl: owns the ball-slot pool and sequences a ball split.
// A hit hides the ball, waits POP_FRAMES frames, then spawns up to two
// next-smaller balls into the lowest free slots.
//   clk, resetN : clock, asynchronous active-low reset
//   bus (slave) : frame/level pulses and hit vector in; slot visibility,
//                 size, spawn load strobe, pop/busy/cleared flags out
module ball_split_ctrl
    import ball_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = DEF_NUM_SLOTS,
    parameter int unsigned POP_FRAMES = 4,
    parameter logic [10:0] START_X    = 11'd300,
    parameter logic [10:0] START_Y    = 11'd100
) (
    input logic             clk,
    input logic             resetN,
    ball_split_ctrl_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_SLOTS);

    typedef logic [10:0] coord_t;

    ball_state_e                state_q, state_d;
    logic       [NUM_SLOTS-1:0] vis_q, vis_d;
    logic       [NUM_SLOTS-1:0] pend_q, pend_d;
    ball_size_t [NUM_SLOTS-1:0] size_q, size_d;
    coord_t     [NUM_SLOTS-1:0] pos_x_q, pos_x_d;
    coord_t     [NUM_SLOTS-1:0] pos_y_q, pos_y_d;
    logic       [3:0]           frame_cnt_q, frame_cnt_d;
    ball_size_t                 saved_size_q, saved_size_d;
    coord_t                     saved_x_q, saved_x_d;
    coord_t                     saved_y_q, saved_y_d;
    logic                       spawn_valid_q, spawn_valid_d;
    logic       [IDX_W-1:0]     spawn_slot_q, spawn_slot_d;
    coord_t                     spawn_x_q, spawn_x_d;
    coord_t                     spawn_y_q, spawn_y_d;
    logic                       dir_right_q, dir_right_d;
    logic                       pop_q, pop_d;
    logic                       busy_q, busy_d;
    logic                       cleared_q, cleared_d;

    logic [NUM_SLOTS-1:0] accept;
    logic [IDX_W-1:0]     pend_idx, free_idx;
    logic                 pend_found, free_found;

    lowest_index_finder #(.WIDTH(NUM_SLOTS), .IDX_W(IDX_W)) u_pend_sel (
        .vec   (pend_q),
        .index (pend_idx),
        .found (pend_found)
    );

    // The slot being popped is already invisible, so it counts as free.
    lowest_index_finder #(.WIDTH(NUM_SLOTS), .IDX_W(IDX_W)) u_free_sel (
        .vec   (~vis_q),
        .index (free_idx),
        .found (free_found)
    );

    // Only visible, not-yet-pending slots accept a hit (and its position).
    assign accept = bus.hit & vis_q & ~pend_q;

    always_comb begin
        state_d       = state_q;
        vis_d         = vis_q;
        size_d        = size_q;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        frame_cnt_d   = frame_cnt_q;
        saved_size_d  = saved_size_q;
        saved_x_d     = saved_x_q;
        saved_y_d     = saved_y_q;
        spawn_valid_d = 1'b0;
        spawn_slot_d  = spawn_slot_q;
        spawn_x_d     = spawn_x_q;
        spawn_y_d     = spawn_y_q;
        dir_right_d   = dir_right_q;
        pend_d        = pend_q | accept;

        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (accept[i]) begin
                pos_x_d[i] = bus.hitX;
                pos_y_d[i] = bus.hitY;
            end
        end

        case (state_q)
            IDLE: begin
                if (pend_found) begin
                    vis_d[pend_idx]  = 1'b0;
                    pend_d[pend_idx] = 1'b0;
                    saved_size_d     = size_q[pend_idx];
                    saved_x_d        = pos_x_q[pend_idx];
                    saved_y_d        = pos_y_q[pend_idx];
                    frame_cnt_d      = 4'(POP_FRAMES);
                    state_d          = POP;
                end
            end
            POP: begin
                if (bus.startOfFrame) begin
                    frame_cnt_d = frame_cnt_q - 4'd1;
                    if (frame_cnt_q == 4'd1) begin
                        state_d = (saved_size_q == SIZE_SMALL) ? IDLE : SPAWN_A;
                    end
                end
            end
            SPAWN_A, SPAWN_B: begin
                // No free slot: this ball is simply dropped.
                if (free_found) begin
                    vis_d[free_idx]  = 1'b1;
                    size_d[free_idx] = saved_size_q - 2'd1;
                    spawn_valid_d    = 1'b1;
                    spawn_slot_d     = free_idx;
                    spawn_x_d        = saved_x_q;
                    spawn_y_d        = saved_y_q;
                    dir_right_d      = (state_q == SPAWN_B);
                end
                state_d = (state_q == SPAWN_A) ? SPAWN_B : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Level restart overrides everything, including hits this cycle.
        if (bus.startLevel) begin
            vis_d         = '0;
            vis_d[0]      = 1'b1;
            size_d        = '0;
            size_d[0]     = SIZE_BIG;
            pend_d        = '0;
            state_d       = IDLE;
            spawn_valid_d = 1'b1;
            spawn_slot_d  = '0;
            spawn_x_d     = START_X;
            spawn_y_d     = START_Y;
            dir_right_d   = 1'b1;
        end

        pop_d     = (state_d == POP);
        busy_d    = (state_d != IDLE);
        cleared_d = (vis_d == '0) && (pend_d == '0) && (state_d == IDLE) && !bus.startLevel;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= IDLE;
            vis_q         <= '0;
            pend_q        <= '0;
            size_q        <= '0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            frame_cnt_q   <= '0;
            saved_size_q  <= SIZE_SMALL;
            saved_x_q     <= '0;
            saved_y_q     <= '0;
            spawn_valid_q <= 1'b0;
            spawn_slot_q  <= '0;
            spawn_x_q     <= '0;
            spawn_y_q     <= '0;
            dir_right_q   <= 1'b0;
            pop_q         <= 1'b0;
            busy_q        <= 1'b0;
            cleared_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            vis_q         <= vis_d;
            pend_q        <= pend_d;
            size_q        <= size_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            frame_cnt_q   <= frame_cnt_d;
            saved_size_q  <= saved_size_d;
            saved_x_q     <= saved_x_d;
            saved_y_q     <= saved_y_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_slot_q  <= spawn_slot_d;
            spawn_x_q     <= spawn_x_d;
            spawn_y_q     <= spawn_y_d;
            dir_right_q   <= dir_right_d;
            pop_q         <= pop_d;
            busy_q        <= busy_d;
            cleared_q     <= cleared_d;
        end
    end

    assign bus.slotVisible   = vis_q;
    assign bus.slotSize      = size_q;
    assign bus.spawnValid    = spawn_valid_q;
    assign bus.spawnSlot     = spawn_slot_q;
    assign bus.spawnX        = spawn_x_q;
    assign bus.spawnY        = spawn_y_q;
    assign bus.spawnDirRight = dir_right_q;
    assign bus.popActive     = pop_q;
    assign bus.busy          = busy_q;
    assign bus.allCleared    = cleared_q;

endmodule
